// File: rtl/pipe_reg_elastic.sv
// Elastic pipeline register: DEPTH chained two-entry skid stages with a
// valid/ready handshake, flush and an occupancy counter. Every output,
// including ready_o, comes straight from a flop, so there is no
// combinational path from ready_i to ready_o or from valid_i to valid_o.

// One elastic stage. It holds up to two words: main drives downstream and
// skid catches the word that arrives while downstream is stalled.
module pipe_reg_elastic_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [WIDTH-1:0] dn_data
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FULL  = 2'b10
    } stage_state_t;

    stage_state_t     state_r;
    stage_state_t     state_nxt_s;
    logic             ready_r;
    logic             valid_r;
    logic [WIDTH-1:0] main_r;
    logic [WIDTH-1:0] skid_r;
    logic             in_fire_s;
    logic             out_fire_s;
    logic             load_main_in_s;
    logic             load_main_skid_s;
    logic             load_skid_s;

    assign up_ready = ready_r;
    assign dn_valid = valid_r;
    assign dn_data  = main_r;

    // Next-state and data-load decode; flush empties the stage without touching data.
    always_comb begin
        in_fire_s        = up_valid & ready_r;
        out_fire_s       = valid_r & dn_ready;
        state_nxt_s      = state_r;
        load_main_in_s   = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        if (flush_i) begin
            state_nxt_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        state_nxt_s    = ST_BUSY;
                        load_main_in_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_BUSY: begin
                    if (in_fire_s && !out_fire_s) begin
                        state_nxt_s = ST_FULL;
                        load_skid_s = 1'b1;
                    end else if (!in_fire_s && out_fire_s) begin
                        state_nxt_s = ST_EMPTY;
                    end else if (in_fire_s && out_fire_s) begin
                        state_nxt_s    = ST_BUSY;
                        load_main_in_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_BUSY;
                    end
                end
                ST_FULL: begin
                    // ready_r is low here, so no input can arrive in this state.
                    if (out_fire_s) begin
                        state_nxt_s      = ST_BUSY;
                        load_main_skid_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
                default: begin
                    state_nxt_s = ST_EMPTY;
                end
            endcase
        end
    end

    // State, registered handshake flags and data registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_EMPTY;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
            main_r  <= {WIDTH{1'b0}};
            skid_r  <= {WIDTH{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s != ST_FULL);
            valid_r <= (state_nxt_s != ST_EMPTY);
            if (load_main_in_s) begin
                main_r <= up_data;
            end else if (load_main_skid_s) begin
                main_r <= skid_r;
            end else begin
                main_r <= main_r;
            end
            if (load_skid_s) begin
                skid_r <= up_data;
            end else begin
                skid_r <= skid_r;
            end
        end
    end

endmodule

// Top: chain of DEPTH stages plus the occupancy counter.
module pipe_reg_elastic #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1,
    localparam int CNT_W = $clog2(2*DEPTH+1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] count_o
);

    // Link k feeds stage k; link DEPTH is the downstream interface.
    logic             link_valid [0:DEPTH];
    logic             link_ready [0:DEPTH];
    logic [WIDTH-1:0] link_data  [0:DEPTH];
    logic [CNT_W-1:0] count_r;
    logic             in_fire_s;
    logic             out_fire_s;

    assign link_valid[0]     = valid_i;
    assign link_data[0]      = data_i;
    assign link_ready[DEPTH] = ready_i;

    assign ready_o = link_ready[0];
    assign valid_o = link_valid[DEPTH];
    assign data_o  = link_data[DEPTH];
    assign count_o = count_r;

    assign in_fire_s  = valid_i & ready_o;
    assign out_fire_s = valid_o & ready_i;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        pipe_reg_elastic_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .flush_i  (flush_i),
            .up_valid (link_valid[k]),
            .up_ready (link_ready[k]),
            .up_data  (link_data[k]),
            .dn_valid (link_valid[k+1]),
            .dn_ready (link_ready[k+1]),
            .dn_data  (link_data[k+1])
        );
    end

    // Occupancy: +1 on accept only, -1 on deliver only, cleared by flush.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_r <= {CNT_W{1'b0}};
        end else if (flush_i) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            case ({in_fire_s, out_fire_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Directed and randomised bench for pipe_reg_elastic (WIDTH=8, DEPTH=3)
// with a queue reference model of the words held.
module tb_pipe_reg_elastic;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       flush_i;
    logic       valid_i;
    logic       ready_o;
    logic [7:0] data_i;
    logic       valid_o;
    logic       ready_i;
    logic [7:0] data_o;
    logic [2:0] count_o;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         acc_cnt  = 0;
    logic [7:0] q [$];
    logic       last_hold = 1'b0;
    logic [7:0] last_held = 8'h00;

    pipe_reg_elastic #(
        .WIDTH (8),
        .DEPTH (3)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .count_o (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle from a negedge, update the model at posedge, return at next negedge.
    task automatic cycle(input logic v, input logic [7:0] d, input logic r, input logic f);
        logic       in_f;
        logic       out_f;
        logic       hold_f;
        logic [7:0] held;
        valid_i = v;
        data_i  = d;
        ready_i = r;
        flush_i = f;
        in_f    = v & ready_o & ~f & ~rst_i;
        out_f   = valid_o & r & ~rst_i;
        hold_f  = valid_o & ~r & ~f & ~rst_i;
        held    = data_o;
        @(posedge clk_i);
        if (rst_i) begin
            q.delete();
        end else begin
            if (out_f && q.size() > 0) void'(q.pop_front());
            if (f) q.delete();
            else if (in_f) begin
                q.push_back(d);
                acc_cnt++;
            end
        end
        @(negedge clk_i);
        last_hold = hold_f;
        last_held = held;
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_valid"}, 32'(valid_o), 32'd0);
        check_val({tag, "_ready"}, 32'(ready_o), 32'd1);
        check_val({tag, "_data"},  32'(data_o),  32'd0);
        check_val({tag, "_count"}, 32'(count_o), 32'd0);
    endtask

    task automatic check_invariants();
        check_val("cnt_model", 32'(count_o), 32'(q.size()));
        check_val("cnt_max", 32'(count_o <= 3'd6), 32'd1);
        if (valid_o) check_val("data_order", 32'(data_o), 32'(q[0]));
        if (last_hold) begin
            check_val("hold_valid", 32'(valid_o), 32'd1);
            check_val("hold_data", 32'(data_o), 32'(last_held));
        end
    endtask

    initial begin
        int k;
        rst_i   = 1'b1;
        flush_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        data_i  = 8'h00;
        @(negedge clk_i);

        // Test 1: reset held two cycles with valid_i asserted
        cycle(1'b1, 8'h55, 1'b0, 1'b0);
        cycle(1'b1, 8'h56, 1'b0, 1'b0);
        check_reset_state("rst1");
        rst_i = 1'b0;

        // Test 2: back-to-back stream 0x01..0x10 with ready_i=1
        for (int i = 0; i <= 18; i++) begin
            cycle(i < 16, 8'(i + 1), 1'b1, 1'b0);
            check_val("s2_valid", 32'(valid_o), 32'(i >= 2 && i <= 17));
            if (i >= 2 && i <= 17) check_val("s2_data", 32'(data_o), 32'(i - 1));
            check_val("s2_ready", 32'(ready_o), 32'd1);
            check_val("s2_cnt_le3", 32'(count_o <= 3'd3), 32'd1);
            check_val("s2_cnt", 32'(count_o), 32'(q.size()));
        end

        // Test 3: fill with ready_i=0, then drain in order
        acc_cnt = 0;
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        check_val("fill_accepted", 32'(acc_cnt), 32'd6);
        check_val("fill_ready", 32'(ready_o), 32'd0);
        check_val("fill_count", 32'(count_o), 32'd6);
        check_val("fill_data", 32'(data_o), 32'h20);
        check_val("fill_valid", 32'(valid_o), 32'd1);
        k = 0;
        for (int i = 0; i < 20; i++) begin
            if (valid_o) begin
                check_val("drain_data", 32'(data_o), 32'(8'h20 + k));
                k++;
            end
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end
        check_val("drain_words", 32'(k), 32'd6);
        check_val("drain_valid", 32'(valid_o), 32'd0);
        check_val("drain_count", 32'(count_o), 32'd0);

        // Test 4: flush at count 4 while offering 0xAA
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        check_val("pre_flush_count", 32'(count_o), 32'd4);
        cycle(1'b1, 8'hAA, 1'b0, 1'b1);
        check_val("flush_valid", 32'(valid_o), 32'd0);
        check_val("flush_count", 32'(count_o), 32'd0);
        check_val("flush_ready", 32'(ready_o), 32'd1);
        check_val("flush_data_kept", 32'(data_o), 32'h30);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            check_val("post_flush_valid", 32'(valid_o), 32'd0);
            check_val("no_aa", 32'(data_o == 8'hAA), 32'd0);
        end

        // Test 5: reset mid-stream at count 5
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        check_val("pre_rst_count", 32'(count_o), 32'd5);
        rst_i = 1'b1;
        cycle(1'b1, 8'h77, 1'b0, 1'b0);
        check_reset_state("rst5");
        rst_i = 1'b0;

        // Test 6: random valid/ready/flush against the queue model
        for (int i = 0; i < 4000; i++) begin
            logic rv;
            logic rr;
            logic rf;
            rv = ($urandom_range(9, 0) < 7);
            rr = (i % 200 < 40) ? 1'b0 : ($urandom_range(9, 0) < 6);
            rf = ($urandom_range(99, 0) < 2);
            cycle(rv, 8'($urandom), rr, rf);
            check_invariants();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
